// File: rtl/bus_read_controller.sv
// Read controller for a shared tri-state register bus: enables one register via cs_n,
// waits a Tick-qualified settle time, captures bus_in and offers it as a response.
module bus_read_controller #(
  parameter int NrOfBits     = 8,
  parameter int NrOfRegs     = 4,
  parameter int AddrBits     = 2,
  parameter int SettleCycles = 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Tick,
  input  logic                req_valid,
  input  logic [AddrBits-1:0] req_addr,
  output logic                req_ready,
  output logic [NrOfRegs-1:0] cs_n,
  input  logic [NrOfBits-1:0] bus_in,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [NrOfBits-1:0] rsp_data,
  output logic                rsp_err,
  output logic                busy
);

  // A settle time of zero would capture before the register drives, so clamp to one.
  localparam int SettleEff = (SettleCycles < 1) ? 1 : SettleCycles;
  localparam int CntBits   = $clog2(SettleEff + 1);
  localparam logic [CntBits-1:0]  CntLoad  = CntBits'(SettleEff);
  localparam logic [AddrBits:0]   RegCount = (AddrBits + 1)'(NrOfRegs);

  typedef enum logic [1:0] {IDLE, SELECT, RESPOND} state_t;

  state_t              state, state_nxt;
  logic [CntBits-1:0]  cnt, cnt_nxt;
  logic [NrOfRegs-1:0] cs_n_nxt;
  logic [NrOfRegs-1:0] sel_onehot;
  logic [NrOfBits-1:0] rsp_data_nxt;
  logic                rsp_err_nxt;
  logic                addr_ok;

  assign addr_ok   = ({1'b0, req_addr} < RegCount);
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESPOND);
  assign busy      = (state != IDLE);

  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < NrOfRegs; i++) begin
      if (req_addr == AddrBits'(i)) sel_onehot[i] = 1'b1;
    end
  end

  // cs_n only changes from all-ones to one-low or back, so a new selection always
  // passes through IDLE with every register released first.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    cs_n_nxt     = cs_n;
    rsp_data_nxt = rsp_data;
    rsp_err_nxt  = rsp_err;
    if (Tick) begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (addr_ok) begin
              state_nxt = SELECT;
              cnt_nxt   = CntLoad;
              cs_n_nxt  = ~sel_onehot;
            end else begin
              state_nxt    = RESPOND;
              rsp_err_nxt  = 1'b1;
              rsp_data_nxt = '0;
              cs_n_nxt     = '1;
            end
          end
        end
        SELECT: begin
          if (cnt == CntBits'(1)) begin
            state_nxt    = RESPOND;
            cnt_nxt      = '0;
            rsp_data_nxt = bus_in;
            rsp_err_nxt  = 1'b0;
            cs_n_nxt     = '1;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        RESPOND: begin
          if (rsp_ready) state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
          cs_n_nxt  = '1;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      cs_n     <= '1;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cs_n     <= cs_n_nxt;
      rsp_data <= rsp_data_nxt;
      rsp_err  <= rsp_err_nxt;
    end
  end

  a_cs_onehot0 : assert property (@(posedge Clock) disable iff (Reset) $onehot0(~cs_n));

endmodule

// File: tb/tb_bus_read_controller.sv
// Scoreboard bench for bus_read_controller: a register-file bus model, randomized
// reads and Tick patterns, and a monitor checking responses against a queue.
module tb_bus_read_controller;

  localparam int NrOfBits     = 8;
  localparam int NrOfRegs     = 3;
  localparam int AddrBits     = 2;
  localparam int SettleCycles = 3;

  logic                Clock     = 1'b0;
  logic                Reset     = 1'b0;
  logic                Tick      = 1'b1;
  logic                req_valid = 1'b0;
  logic [AddrBits-1:0] req_addr  = '0;
  logic                rsp_ready = 1'b1;
  logic                req_ready, rsp_valid, rsp_err, busy;
  logic [NrOfRegs-1:0] cs_n;
  logic [NrOfBits-1:0] bus_in, rsp_data;
  logic [NrOfBits-1:0] junk = '0;
  logic [NrOfBits-1:0] regs [NrOfRegs];

  typedef struct {
    logic [NrOfBits-1:0] data;
    logic                err;
    int                  lat;
    logic [NrOfRegs-1:0] cs;
  } exp_t;

  exp_t sb[$];
  exp_t e_new;
  int   checks = 0;
  int   passes = 0;
  int   phase = 0;
  int   lat = 0;
  int   wcnt = 0;
  int   tick_mode = 0;
  bit   ready_rand = 1'b0;
  logic [NrOfBits-1:0] last_data = '0;
  logic [NrOfRegs-1:0] prev_cs = '1;

  bus_read_controller #(
    .NrOfBits(NrOfBits), .NrOfRegs(NrOfRegs), .AddrBits(AddrBits), .SettleCycles(SettleCycles)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .cs_n(cs_n), .bus_in(bus_in), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 Clock = ~Clock;

  // Only a register whose output-disable is the single low bit drives the bus.
  always_comb begin
    bus_in = junk;
    for (int i = 0; i < NrOfRegs; i++) begin
      if (cs_n == ~(3'b001 << i)) bus_in = regs[i];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input logic [AddrBits-1:0] addr);
    int n = 0;
    @(posedge Clock); #1;
    req_valid = 1'b1;
    req_addr  = addr;
    @(negedge Clock);
    while (!(Tick && req_ready) && n < 300) begin
      @(negedge Clock);
      n++;
    end
    if (!(Tick && req_ready)) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge Clock); #1;
    req_valid = 1'b0;
    req_addr  = AddrBits'($urandom);
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge Clock);
    while (phase != 0 && n < 300) begin
      @(negedge Clock);
      n++;
    end
    if (phase != 0) checkOutput("idle_timeout", 32'd0, 32'd1);
  endtask

  // Background input activity: Tick pattern, bus junk and optional random rsp_ready.
  initial begin
    forever begin
      @(posedge Clock); #1;
      junk = NrOfBits'($urandom);
      case (tick_mode)
        0:       Tick = 1'b1;
        1:       Tick = ~Tick;
        default: Tick = ($urandom_range(0, 3) != 0);
      endcase
      if (ready_rand) rsp_ready = ($urandom_range(0, 2) != 0);
    end
  end

  always @(posedge Reset) begin
    sb.delete();
    phase     = 0;
    last_data = '0;
    prev_cs   = '1;
  end

  // Monitor: inputs are stable at the falling edge, so it predicts what the next
  // rising edge does and checks what the previous one produced.
  always @(negedge Clock) begin
    if (!Reset) begin
      if (cs_n != '1 && prev_cs != '1) checkOutput("break_before_make", 32'(cs_n), 32'(prev_cs));
      prev_cs = cs_n;
      if (phase == 0) begin
        checkOutput("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_req_ready", 32'(req_ready), 32'd1);
        checkOutput("idle_cs_n", 32'(cs_n), 32'(3'b111));
        checkOutput("idle_rsp_data", 32'(rsp_data), 32'(last_data));
        if (Tick && req_valid && req_ready) begin
          if (req_addr < 2'(NrOfRegs)) begin
            e_new = '{regs[req_addr], 1'b0, SettleCycles, ~(3'b001 << req_addr)};
          end else begin
            e_new = '{8'h00, 1'b1, 0, 3'b111};
          end
          sb.push_back(e_new);
          phase = 1;
          lat   = 0;
          wcnt  = 0;
        end
      end else if (phase == 1) begin
        if (rsp_valid) begin
          checkOutput("latency_ticks", 32'(lat), 32'(sb[0].lat));
          phase = 2;
        end else begin
          checkOutput("select_cs_n", 32'(cs_n), 32'(sb[0].cs));
          checkOutput("select_busy", 32'(busy), 32'd1);
          checkOutput("select_req_ready", 32'(req_ready), 32'd0);
          if (Tick) lat++;
          wcnt++;
          if (wcnt > 200) begin
            checkOutput("rsp_timeout", 32'd0, 32'd1);
            sb.delete();
            phase = 0;
          end
        end
      end
      if (phase == 2) begin
        checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("rsp_data", 32'(rsp_data), 32'(sb[0].data));
        checkOutput("rsp_err", 32'(rsp_err), 32'(sb[0].err));
        checkOutput("respond_cs_n", 32'(cs_n), 32'(3'b111));
        checkOutput("respond_req_ready", 32'(req_ready), 32'd0);
        if (Tick && rsp_ready) begin
          last_data = sb[0].data;
          void'(sb.pop_front());
          phase = 0;
        end
      end
    end
  end

  initial begin
    int n;
    regs[0] = 8'h11;
    regs[1] = 8'h3C;
    regs[2] = 8'hA5;
    #1 Reset = 1'b1;
    #2;
    checkOutput("reset_cs_n", 32'(cs_n), 32'(3'b111));
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("reset_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b0;
    repeat (2) @(posedge Clock);

    // Plain read, nonexistent register, and a response held off for five cycles.
    applyStimulus(2'd2);
    waitIdle();
    applyStimulus(2'd3);
    waitIdle();
    rsp_ready = 1'b0;
    applyStimulus(2'd1);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge Clock);
      n++;
    end
    repeat (5) @(posedge Clock);
    #1 rsp_ready = 1'b1;
    waitIdle();

    // Alternating Tick while a selection is settling.
    @(posedge Clock); #1;
    regs[2]   = 8'h5A;
    tick_mode = 1;
    applyStimulus(2'd2);
    waitIdle();
    tick_mode = 0;

    // Reset in the middle of a selection must release cs_n without a clock edge.
    applyStimulus(2'd0);
    @(negedge Clock);
    checkOutput("pre_reset_cs_n", 32'(cs_n), 32'(3'b110));
    #1 Reset = 1'b1;
    #1;
    checkOutput("async_reset_cs_n", 32'(cs_n), 32'(3'b111));
    checkOutput("async_reset_busy", 32'(busy), 32'd0);
    checkOutput("async_reset_req_ready", 32'(req_ready), 32'd1);
    @(posedge Clock); #1 Reset = 1'b0;
    repeat (4) @(posedge Clock);

    // Back-to-back reads of different registers.
    applyStimulus(2'd0);
    applyStimulus(2'd1);
    waitIdle();

    tick_mode  = 2;
    ready_rand = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k % 3 != 0) begin
        waitIdle();
        @(posedge Clock); #1;
        for (int i = 0; i < NrOfRegs; i++) regs[i] = NrOfBits'($urandom);
      end
      applyStimulus(AddrBits'($urandom_range(0, 3)));
    end
    ready_rand = 1'b0;
    rsp_ready  = 1'b1;
    tick_mode  = 0;
    waitIdle();
    repeat (3) @(posedge Clock);
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
